// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
//   Shared constants and helpers for the decoder-based 1-bit full adder.
//   SUM_MINTERMS / CARRY_MINTERMS select the decoder lines that make each
//   output true. Bit k of a mask corresponds to minterm m_k, where
//   k = {a,b,c} and a is the MSB.
//   minterm_or() ORs together the selected one-hot decoder lines.
// -----------------------------------------------------------------------------
package full_adder_pkg;

  localparam int IDX_WIDTH = 3;
  localparam int DEC_WIDTH = 1 << IDX_WIDTH;

  // sum is odd parity: m1, m2, m4, m7
  localparam logic [DEC_WIDTH-1:0] SUM_MINTERMS   = 8'b1001_0110;
  // carry is majority: m3, m5, m6, m7
  localparam logic [DEC_WIDTH-1:0] CARRY_MINTERMS = 8'b1110_1000;

  // Result pair, kept in truth-table order {carry, sum}
  typedef struct packed {
    logic carry;
    logic sum;
  } fa_out_t;

  // Because dec is one-hot, the AND-then-OR gives 1 exactly when the active
  // line is one of the minterms in mask.
  function automatic logic minterm_or(input logic [DEC_WIDTH-1:0] dec,
                                      input logic [DEC_WIDTH-1:0] mask);
    return |(dec & mask);
  endfunction

endpackage

// File: rtl/decoder_3to8.sv
// -----------------------------------------------------------------------------
// decoder_3to8
//   Pure combinational 3-to-8 line decoder with one-hot output.
//   Ports:
//     in   [2:0]  binary select
//     out  [7:0]  one-hot; out[in] = 1, all other bits 0
// -----------------------------------------------------------------------------
module decoder_3to8
  import full_adder_pkg::*;
(
  input  logic [IDX_WIDTH-1:0] in,
  output logic [DEC_WIDTH-1:0] out
);

  // Each line is its own equality compare. An X on the input therefore
  // gives X on the output, and no line is silently forced high.
  genvar gi;
  generate
    for (gi = 0; gi < DEC_WIDTH; gi++) begin : g_line
      assign out[gi] = (in == IDX_WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/full_adder_decoder.sv
// -----------------------------------------------------------------------------
// full_adder_decoder
//   1-bit full adder built from a 3-to-8 minterm decoder followed by a masked
//   OR-reduction. It serves as the leaf cell of ripple-carry chains.
//   Parameters:
//     REG_OUT  1: sum and carry are registered on clk, giving 1 cycle of latency.
//              0: sum and carry are combinational, and clk and rst are unused.
//   Ports:
//     clk    rising-edge clock
//     rst    synchronous, active-high reset; clears sum and carry
//     a, b   addend bits
//     c      carry-in bit
//     carry  carry-out = majority(a,b,c)
//     sum    a ^ b ^ c
// -----------------------------------------------------------------------------
module full_adder_decoder
  import full_adder_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic carry,
  output logic sum
);

  logic [IDX_WIDTH-1:0] idx;
  logic [DEC_WIDTH-1:0] dec;
  fa_out_t              res_d;

  // a is the MSB, so the index reads directly as the minterm number
  assign idx = {a, b, c};

  decoder_3to8 u_dec (
    .in  (idx),
    .out (dec)
  );

  assign res_d.sum   = minterm_or(dec, SUM_MINTERMS);
  assign res_d.carry = minterm_or(dec, CARRY_MINTERMS);

  // Simulation-only sanity check on the decoder. X inputs are excluded
  // because they are allowed to make the outputs X.
  always_comb begin
    if (!$isunknown(idx)) begin
      assert ($onehot(dec));
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      fa_out_t res_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          res_q <= '0;
        end else begin
          res_q <= res_d;
        end
      end

      assign sum   = res_q.sum;
      assign carry = res_q.carry;
    end else begin : g_comb
      // No state in this branch. clk and rst are tied off here so they
      // still count as used.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst};

      assign sum   = res_d.sum;
      assign carry = res_d.carry;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder_decoder.sv
// -----------------------------------------------------------------------------
// tb_full_adder_decoder
//   Scoreboarded bench for full_adder_decoder.
//   u_reg uses REG_OUT=1 and a free-running clk.
//   u_comb uses REG_OUT=0 with a static clock and reset.
// -----------------------------------------------------------------------------
module tb_full_adder_decoder;

  logic clk;
  logic rst;
  logic a, b, c;
  logic carry, sum;

  logic clk_s, rst_s;
  logic ac, bc, cc;
  logic carry_c, sum_c;

  int checks;
  int errors;

  // Expected {carry,sum}; pushed when a vector is driven, popped at output time
  logic [1:0] sb [$];

  // Truth table indexed by {a,b,c}
  logic [1:0] tt [0:7] = '{2'b00, 2'b01, 2'b01, 2'b10,
                           2'b01, 2'b10, 2'b10, 2'b11};

  full_adder_decoder #(.REG_OUT(1'b1)) u_reg (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c     (c),
    .carry (carry),
    .sum   (sum)
  );

  full_adder_decoder #(.REG_OUT(1'b0)) u_comb (
    .clk   (clk_s),
    .rst   (rst_s),
    .a     (ac),
    .b     (bc),
    .c     (cc),
    .carry (carry_c),
    .sum   (sum_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one vector, queues its expected result, then waits until just after
  // the edge that registers it. Inputs change only at posedge+1.
  task automatic apply(input logic r, input logic [2:0] v);
    logic [1:0] exp_v;
    rst = r;
    {a, b, c} = v;
    exp_v = r ? 2'b00 : tt[v];
    sb.push_back(exp_v);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] got, exp_v;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 3'b111);
      got = {carry, sum};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, got, exp_v);
      end else
        $display("reset_hold cyc=%0d {carry,sum}=%b", i, got);
    end
    apply(1'b0, 3'b111);
    got = {carry, sum};
    exp_v = sb.pop_front();
    checks++;
    if (got !== 2'b11 || exp_v !== 2'b11) begin
      errors++;
      $display("FAIL reset_release got=%b exp=11", got);
    end else
      $display("reset_release {carry,sum}=%b", got);
  endtask

  task automatic test_sweep();
    logic [1:0] got, exp_v;
    for (int v = 0; v < 8; v++) begin
      apply(1'b0, 3'(v));
      got = {carry, sum};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL sweep abc=%03b got=%b exp=%b", 3'(v), got, exp_v);
      end else
        $display("sweep abc=%03b {carry,sum}=%b", 3'(v), got);
    end
  endtask

  task automatic test_hold();
    logic [1:0] got, exp_v;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 3'b011);
      got = {carry, sum};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v || got !== 2'b10) begin
        errors++;
        $display("FAIL hold_011 cyc=%0d got=%b exp=10", i, got);
      end else
        $display("hold_011 cyc=%0d {carry,sum}=%b", i, got);
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] got, exp_v;
    for (int v = 0; v < 7; v++) begin
      apply(1'b0, 3'(v));
      void'(sb.pop_front());
    end
    // Reset lands while 110 (expected 10) is still on the inputs
    apply(1'b1, 3'b110);
    got = {carry, sum};
    exp_v = sb.pop_front();
    checks++;
    if (got !== exp_v || got !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset got=%b exp=00", got);
    end else
      $display("mid_reset abc=110 {carry,sum}=%b", got);
    apply(1'b0, 3'b101);
    got = {carry, sum};
    exp_v = sb.pop_front();
    checks++;
    if (got !== exp_v || got !== 2'b10) begin
      errors++;
      $display("FAIL resume_101 got=%b exp=10", got);
    end else
      $display("resume_101 {carry,sum}=%b", got);
  endtask

  task automatic test_comb();
    logic [1:0] got, exp_v;
    for (int v = 0; v < 8; v++) begin
      {ac, bc, cc} = 3'(v);
      sb.push_back(tt[v]);
      #1;
      got = {carry_c, sum_c};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL comb abc=%03b got=%b exp=%b", 3'(v), got, exp_v);
      end else
        $display("comb abc=%03b {carry,sum}=%b", 3'(v), got);
      #9;
    end
  endtask

  task automatic test_random();
    logic [1:0] got, exp_v;
    logic [2:0] v;
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      v = 3'($urandom_range(0, 7));
      rst = 1'b0;
      {a, b, c} = v;
      // Arithmetic reference, independent of the minterm masks
      sb.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
      @(posedge clk);
      #1;
      got = {carry, sum};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        bad++;
        $display("FAIL random i=%0d abc=%03b got=%b exp=%b", i, v, got, exp_v);
      end
    end
    $display("random 1000 vectors, %0d bad", bad);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    {a, b, c} = 3'b000;
    clk_s = 1'b0;
    rst_s = 1'b0;
    {ac, bc, cc} = 3'b000;
    @(posedge clk);
    #1;
    test_reset();
    test_sweep();
    test_hold();
    test_mid_reset();
    test_comb();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
